hashcheck_sched: RTL and testbench

- Sequences the shared hash checker, which holds up to 128 target NT hashes, between one host target-load port and NUM_CORES cracking cores that emit candidate hashes.
- Arbitrates requests and drives the checker's newrdy/checkrdy/hash handshake.
- Waits out the checker's resultrdy protocol and reports hits with the originating core id.
- Sits between the core array and the checker instance in the top level.

---
 rtl/hashcheck_pkg.sv | 20 ++
 rtl/hashcheck_sched_if.sv | 15 +
 rtl/hashcheck_sched_rr_arbiter.sv | 31 +++
 rtl/hashcheck_sched.sv | 192 +++++++++++++++++++
 tb/tb_hashcheck_sched.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hashcheck_pkg.sv
// Shared types and constants for the hash-checker scheduler.
package hashcheck_pkg;

  localparam int HASH_W      = 128;
  localparam int MAX_TARGETS = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_CHECK = 1'b1
  } op_t;

endpackage

// File: rtl/hashcheck_sched_if.sv
// Handshake bundle between the scheduler and the shared hash checker.
interface hashcheck_sched_if;
  import hashcheck_pkg::*;

  logic              newrdy;
  logic              checkrdy;
  logic [HASH_W-1:0] hash;
  logic              resultrdy;
  logic              matchfound;

  modport master (output newrdy, output checkrdy, output hash,
                  input resultrdy, input matchfound);
  modport slave  (input newrdy, input checkrdy, input hash,
                  output resultrdy, output matchfound);
endinterface

// File: rtl/hashcheck_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Scan from ptr; the first taken slot masks every later one.
  always_comb begin
    int   idx_s;
    logic take_s;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx_s     = 0;
    take_s    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s        = (int'(ptr) + k) % N;
      take_s       = req[idx_s] & ~any;
      grant[idx_s] = take_s;
      grant_idx    = take_s ? IDX_W'(idx_s) : grant_idx;
      any          = any | take_s;
    end
  end

endmodule

// File: rtl/hashcheck_sched.sv
// Sequences target loads and candidate checks onto one shared hash checker.
module hashcheck_sched
  import hashcheck_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int CORE_W         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [HASH_W-1:0]           load_hash,
  output logic                        load_ready,
  input  logic [NUM_CORES-1:0]        cand_valid,
  input  logic [NUM_CORES*HASH_W-1:0] cand_hash,
  output logic [NUM_CORES-1:0]        cand_ready,
  output logic                        hit_valid,
  output logic [CORE_W-1:0]           hit_core,
  output logic [HASH_W-1:0]           hit_hash,
  output logic [7:0]                  targets_loaded,
  output logic                        table_full,
  output logic                        timeout_err,
  hashcheck_sched_if.master           chk
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_r, state_nxt_s;
  op_t                   op_r, op_nxt_s;
  logic [CORE_W-1:0]     cur_core_r, cur_core_nxt_s, rr_ptr_r, rr_ptr_nxt_s;
  logic [HASH_W-1:0]     chk_hash_r, chk_hash_nxt_s, hit_hash_r, hit_hash_nxt_s;
  logic                  match_r, match_nxt_s;
  logic [TMR_W-1:0]      tmr_r, tmr_nxt_s;
  logic [7:0]            count_r, count_nxt_s;
  logic                  terr_r, terr_nxt_s, full_r;
  logic                  load_ready_r, load_ready_nxt_s;
  logic [NUM_CORES-1:0]  cand_ready_r, cand_ready_nxt_s;
  logic                  newrdy_r, newrdy_nxt_s, checkrdy_r, checkrdy_nxt_s;
  logic                  hit_valid_r, hit_valid_nxt_s;
  logic [CORE_W-1:0]     hit_core_r, hit_core_nxt_s;
  logic [NUM_CORES-1:0]  arb_grant_s;
  logic [CORE_W-1:0]     arb_idx_s;
  logic                  arb_any_s, tmo_s;

  rr_arbiter #(.N(NUM_CORES), .IDX_W(CORE_W)) u_arb (
    .req(cand_valid), .ptr(rr_ptr_r),
    .grant(arb_grant_s), .grant_idx(arb_idx_s), .any(arb_any_s)
  );

  assign tmo_s = (tmr_r == TMR_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; every registered value defaults to hold, pulses to 0.
  always_comb begin
    state_nxt_s      = state_r;
    op_nxt_s         = op_r;
    cur_core_nxt_s   = cur_core_r;
    rr_ptr_nxt_s     = rr_ptr_r;
    chk_hash_nxt_s   = chk_hash_r;
    match_nxt_s      = match_r;
    tmr_nxt_s        = tmr_r;
    count_nxt_s      = count_r;
    terr_nxt_s       = terr_r;
    load_ready_nxt_s = 1'b0;
    cand_ready_nxt_s = '0;
    newrdy_nxt_s     = 1'b0;
    checkrdy_nxt_s   = 1'b0;
    hit_valid_nxt_s  = 1'b0;
    hit_core_nxt_s   = hit_core_r;
    hit_hash_nxt_s   = hit_hash_r;
    case (state_r)
      ST_IDLE: begin
        if (load_valid && !full_r) begin
          load_ready_nxt_s = 1'b1;
          chk_hash_nxt_s   = load_hash;
          op_nxt_s         = OP_LOAD;
          newrdy_nxt_s     = 1'b1;
          state_nxt_s      = ST_ISSUE;
        end else if (arb_any_s) begin
          cand_ready_nxt_s = arb_grant_s;
          chk_hash_nxt_s   = cand_hash[int'(arb_idx_s)*HASH_W +: HASH_W];
          cur_core_nxt_s   = arb_idx_s;
          if (int'(arb_idx_s) == NUM_CORES - 1) begin
            rr_ptr_nxt_s = '0;
          end else begin
            rr_ptr_nxt_s = arb_idx_s + CORE_W'(1);
          end
          op_nxt_s       = OP_CHECK;
          checkrdy_nxt_s = 1'b1;
          state_nxt_s    = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmr_nxt_s   = '0;
        state_nxt_s = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (chk.resultrdy) begin
          match_nxt_s = chk.matchfound;
          tmr_nxt_s   = '0;
          state_nxt_s = ST_WAIT_LO;
        end else if (tmo_s) begin
          terr_nxt_s  = 1'b1;
          tmr_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          tmr_nxt_s = tmr_r + TMR_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!chk.resultrdy) begin
          tmr_nxt_s   = '0;
          state_nxt_s = ST_DONE;
        end else if (tmo_s) begin
          terr_nxt_s  = 1'b1;
          tmr_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          tmr_nxt_s = tmr_r + TMR_W'(1);
        end
      end
      ST_DONE: begin
        if (op_r == OP_LOAD) begin
          count_nxt_s = count_r + 8'd1;
        end else if (match_r) begin
          hit_valid_nxt_s = 1'b1;
          hit_core_nxt_s  = cur_core_r;
          hit_hash_nxt_s  = chk_hash_r;
        end else begin
          hit_valid_nxt_s = 1'b0;
        end
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_LOAD;
      cur_core_r   <= '0;
      rr_ptr_r     <= '0;
      chk_hash_r   <= '0;
      match_r      <= 1'b0;
      tmr_r        <= '0;
      count_r      <= 8'd0;
      full_r       <= 1'b0;
      terr_r       <= 1'b0;
      load_ready_r <= 1'b0;
      cand_ready_r <= '0;
      newrdy_r     <= 1'b0;
      checkrdy_r   <= 1'b0;
      hit_valid_r  <= 1'b0;
      hit_core_r   <= '0;
      hit_hash_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      op_r         <= op_nxt_s;
      cur_core_r   <= cur_core_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      chk_hash_r   <= chk_hash_nxt_s;
      match_r      <= match_nxt_s;
      tmr_r        <= tmr_nxt_s;
      count_r      <= count_nxt_s;
      full_r       <= (count_nxt_s == 8'(MAX_TARGETS));
      terr_r       <= terr_nxt_s;
      load_ready_r <= load_ready_nxt_s;
      cand_ready_r <= cand_ready_nxt_s;
      newrdy_r     <= newrdy_nxt_s;
      checkrdy_r   <= checkrdy_nxt_s;
      hit_valid_r  <= hit_valid_nxt_s;
      hit_core_r   <= hit_core_nxt_s;
      hit_hash_r   <= hit_hash_nxt_s;
    end
  end

  assign load_ready     = load_ready_r;
  assign cand_ready     = cand_ready_r;
  assign hit_valid      = hit_valid_r;
  assign hit_core       = hit_core_r;
  assign hit_hash       = hit_hash_r;
  assign targets_loaded = count_r;
  assign table_full     = full_r;
  assign timeout_err    = terr_r;
  assign chk.newrdy     = newrdy_r;
  assign chk.checkrdy   = checkrdy_r;
  assign chk.hash       = chk_hash_r;

endmodule

// File: tb/tb_hashcheck_sched.sv
// Randomized scoreboard bench for hashcheck_sched with a behavioural checker model.
module tb_hashcheck_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [127:0] load_hash;
  logic         load_ready;
  logic [3:0]   cand_valid;
  logic [511:0] cand_hash;
  logic [3:0]   cand_ready;
  logic         hit_valid;
  logic [1:0]   hit_core;
  logic [127:0] hit_hash;
  logic [7:0]   targets_loaded;
  logic         table_full;
  logic         timeout_err;

  hashcheck_sched_if chk_if ();

  hashcheck_sched #(.NUM_CORES(4), .CORE_W(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_hash(load_hash), .load_ready(load_ready),
    .cand_valid(cand_valid), .cand_hash(cand_hash), .cand_ready(cand_ready),
    .hit_valid(hit_valid), .hit_core(hit_core), .hit_hash(hit_hash),
    .targets_loaded(targets_loaded), .table_full(table_full),
    .timeout_err(timeout_err), .chk(chk_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic mute = 1'b0;

  // Reference state owned by the monitor
  logic [127:0] targets[$];
  logic [129:0] exp_q[$];
  int           glog[$];
  int ptr_m = 0;
  int n_load_ready = 0, n_newrdy = 0, n_checkrdy = 0, n_hits = 0;
  logic         prev_load_take = 1'b0;
  logic [127:0] prev_load_hash = '0;
  logic [3:0]   prev_cand_valid = '0;
  logic [511:0] prev_cand_hash = '0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd_hash();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit in_targets(input logic [127:0] h);
    foreach (targets[i]) if (targets[i] == h) return 1'b1;
    return 1'b0;
  endfunction

  // Checker model: stores loads, answers checks after a random delay.
  initial begin
    logic [127:0] ctab[$];
    bit busy = 0, is_chk = 0, hit = 0;
    int dly = 0, hold = 0;
    chk_if.resultrdy  = 1'b0;
    chk_if.matchfound = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy = 0; ctab.delete();
        chk_if.resultrdy = 1'b0; chk_if.matchfound = 1'b0;
      end else if (!busy) begin
        if (chk_if.newrdy) begin
          if (ctab.size() < 128) ctab.push_back(chk_if.hash);
          busy = 1; is_chk = 0; dly = $urandom_range(0, 2); hold = $urandom_range(1, 3);
        end else if (chk_if.checkrdy && !mute) begin
          hit = 0;
          foreach (ctab[i]) if (ctab[i] == chk_if.hash) hit = 1;
          busy = 1; is_chk = 1; dly = $urandom_range(0, 2); hold = 2;
        end
      end else if (dly > 0) begin
        dly--;
      end else if (!chk_if.resultrdy) begin
        chk_if.resultrdy  = 1'b1;
        chk_if.matchfound = is_chk & hit;
      end else begin
        hold--;
        if (hold == 0) begin
          chk_if.resultrdy = 1'b0; chk_if.matchfound = 1'b0; busy = 0;
        end
      end
    end
  end

  // Monitor: predicts grants from the round-robin rule and checks hits against the queue.
  always @(negedge clk) begin
    int g;
    logic [3:0] exp_vec;
    logic [127:0] h;
    logic [129:0] e;
    if (rst) begin
      ptr_m = 0; targets.delete(); exp_q.delete();
    end else begin
      if (cand_ready != 4'b0000) begin
        g = -1; exp_vec = 4'b0000;
        if (!prev_load_take)
          for (int k = 0; k < 4; k++)
            if (g < 0 && prev_cand_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        if (g >= 0) exp_vec[g] = 1'b1;
        check_eq("grant", {124'd0, cand_ready}, {124'd0, exp_vec});
        if (g >= 0) begin
          ptr_m = (g + 1) % 4;
          glog.push_back(g);
          h = prev_cand_hash[g*128 +: 128];
          check_eq("chk_hash_cand", chk_if.hash, h);
          if (!mute && in_targets(h)) exp_q.push_back({g[1:0], h});
        end
      end
      if (load_ready) begin
        n_load_ready++;
        check_eq("load_take", {127'd0, prev_load_take}, 128'd1);
        targets.push_back(prev_load_hash);
        check_eq("chk_hash_load", chk_if.hash, prev_load_hash);
      end
      if (chk_if.newrdy || chk_if.checkrdy) begin
        if (chk_if.newrdy) n_newrdy++;
        if (chk_if.checkrdy) n_checkrdy++;
        check_eq("issue_overlap", {127'd0, chk_if.resultrdy}, 128'd0);
        check_eq("issue_pair", {126'd0, chk_if.newrdy, chk_if.checkrdy},
                 {126'd0, load_ready, |cand_ready});
      end
      if (hit_valid) begin
        n_hits++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_hit", hit_hash, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("hit_core", {126'd0, hit_core}, {126'd0, e[129:128]});
          check_eq("hit_hash", hit_hash, e[127:0]);
        end
      end
    end
    prev_load_take  = load_valid && (targets.size() < 128) && !rst;
    prev_load_hash  = load_hash;
    prev_cand_valid = cand_valid;
    prev_cand_hash  = cand_hash;
  end

  task automatic timeout_fail(input string name);
    checks++; errors++;
    $display("FAIL %s actual=no_response expected=response", name);
  endtask

  task automatic do_load(input logic [127:0] h);
    bit ok = 0;
    @(posedge clk); #2;
    load_valid = 1'b1; load_hash = h;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (load_ready) begin ok = 1; break; end
    end
    load_valid = 1'b0;
    if (!ok) timeout_fail("load_wait");
  endtask

  task automatic do_cand(input int c, input logic [127:0] h);
    bit ok = 0;
    @(posedge clk); #2;
    cand_valid[c] = 1'b1; cand_hash[c*128 +: 128] = h;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (cand_ready[c]) begin ok = 1; break; end
    end
    cand_valid[c] = 1'b0;
    if (!ok) timeout_fail("cand_wait");
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ha, hb, hc, hd, ht;
    int h0, c0, lr0, t_load, t_cand;
    bit got;
    rst = 1'b1; load_valid = 1'b0; load_hash = '0; cand_valid = '0; cand_hash = '0;
    ha = rnd_hash(); hb = rnd_hash(); hc = rnd_hash(); hd = rnd_hash();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outputs", {120'd0, load_ready, cand_ready, hit_valid, table_full, timeout_err},
             128'd0);
    check_eq("rst_count", {120'd0, targets_loaded}, 128'd0);
    check_eq("rst_chk", {chk_if.hash[125:0], chk_if.newrdy, chk_if.checkrdy}, 128'd0);
    @(posedge clk); #2; rst = 1'b0;

    // Three targets
    do_load(ha); do_load(hb); do_load(hc);
    settle(15);
    check_eq("count_3", {120'd0, targets_loaded}, 128'd3);
    check_eq("load_ready_3", 128'(n_load_ready), 128'd3);
    check_eq("newrdy_3", 128'(n_newrdy), 128'd3);
    check_eq("no_hits_load", 128'(n_hits), 128'd0);

    // All cores requesting from rr_ptr=0
    glog.delete(); c0 = n_checkrdy; got = 0;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) cand_hash[i*128 +: 128] = (i == 3) ? ha : rnd_hash();
    cand_valid = 4'b1111;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) if (cand_ready[i]) cand_hash[i*128 +: 128] = rnd_hash();
      if (glog.size() >= 5) begin cand_valid = 4'b0000; got = 1; end
    end
    if (!got) timeout_fail("rr_wait");
    settle(15);
    for (int i = 0; i < 5; i++)
      check_eq("rr_order", 128'(glog.size() > i ? glog[i] : -1), 128'(i % 4));
    check_eq("checkrdy_per_grant", 128'(n_checkrdy - c0), 128'd5);
    check_eq("rr_hit_core3", 128'(n_hits), 128'd1);

    // Core 2 hits B, core 0 misses with D
    h0 = n_hits;
    do_cand(2, hb); settle(15);
    check_eq("hit_b_count", 128'(n_hits - h0), 128'd1);
    check_eq("hit_b_core", {126'd0, hit_core}, 128'd2);
    check_eq("hit_b_hash", hit_hash, hb);
    do_cand(0, hd); settle(15);
    check_eq("miss_d_count", 128'(n_hits - h0), 128'd1);

    // Load and candidate rising together
    t_load = -1; t_cand = -1;
    @(posedge clk); #2;
    load_valid = 1'b1; load_hash = rnd_hash();
    cand_valid[1] = 1'b1; cand_hash[128 +: 128] = rnd_hash();
    for (int cyc = 0; cyc < 300 && (t_load < 0 || t_cand < 0); cyc++) begin
      @(posedge clk); #2;
      if (load_ready) begin t_load = cyc; load_valid = 1'b0; end
      if (cand_ready[1]) begin t_cand = cyc; cand_valid[1] = 1'b0; end
    end
    load_valid = 1'b0; cand_valid = 4'b0000;
    if (t_load < 0 || t_cand < 0) timeout_fail("simul_wait");
    check_eq("load_first", {127'd0, (t_load >= 0 && t_load < t_cand)}, 128'd1);
    settle(15);
    check_eq("count_4", {120'd0, targets_loaded}, 128'd4);

    // Fill the table; the last target is remembered
    ht = '0;
    for (int i = 4; i < 128; i++) begin
      ht = rnd_hash();
      do_load(ht);
    end
    settle(15);
    check_eq("count_128", {120'd0, targets_loaded}, 128'd128);
    check_eq("table_full", {127'd0, table_full}, 128'd1);
    lr0 = n_load_ready; h0 = n_hits; got = 0;
    @(posedge clk); #2;
    load_valid = 1'b1; load_hash = rnd_hash();
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #2;
      if (cyc == 10) begin cand_valid[3] = 1'b1; cand_hash[3*128 +: 128] = ht; end
      if (cand_ready[3]) begin cand_valid[3] = 1'b0; got = 1; end
    end
    load_valid = 1'b0; cand_valid = 4'b0000;
    settle(15);
    check_eq("full_no_load_ready", 128'(n_load_ready - lr0), 128'd0);
    check_eq("full_cand_served", {127'd0, got}, 128'd1);
    check_eq("full_hit_count", 128'(n_hits - h0), 128'd1);
    check_eq("full_hit_hash", hit_hash, ht);
    check_eq("full_hit_core", {126'd0, hit_core}, 128'd3);

    // Unresponsive checker
    mute = 1'b1; h0 = n_hits; got = 0;
    do_cand(1, ha);
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk);
      if (timeout_err) got = 1;
    end
    mute = 1'b0;
    check_eq("timeout_err", {127'd0, timeout_err}, 128'd1);
    settle(10);
    check_eq("timeout_no_hit", 128'(n_hits - h0), 128'd0);
    do_cand(0, hb); settle(15);
    check_eq("after_timeout_hit", 128'(n_hits - h0), 128'd1);
    check_eq("after_timeout_hash", hit_hash, hb);
    check_eq("timeout_sticky", {127'd0, timeout_err}, 128'd1);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rst_clears_timeout", {127'd0, timeout_err}, 128'd0);
    check_eq("rst_clears_count", {119'd0, table_full, targets_loaded}, 128'd0);
    @(posedge clk); #2; rst = 1'b0;
    settle(3);
    check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
